// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a byte-wide data memory between two word requesters.
// Word accesses run as four little-endian byte beats, byte accesses as one beat.
module data_mem_arbiter #(
   parameter int ADDR_W = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_write,
   input  logic              r0_byte,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [31:0]       r0_wdata,
   output logic              r0_ack,
   output logic [31:0]       r0_rdata,
   input  logic              r1_req,
   input  logic              r1_write,
   input  logic              r1_byte,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [31:0]       r1_wdata,
   output logic              r1_ack,
   output logic [31:0]       r1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              grant
);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t            state, state_nxt;
   logic              any_req, win;
   logic [1:0]        beat, last_beat;
   logic              cur_write, cur_byte;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [31:0]       result, resp_result;
   logic [31:0]       rdata0_q, rdata1_q;

   function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] k);
      case (k)
         2'd0:    byte_lane = w[7:0];
         2'd1:    byte_lane = w[15:8];
         2'd2:    byte_lane = w[23:16];
         default: byte_lane = w[31:24];
      endcase
   endfunction

   assign any_req   = r0_req | r1_req;
   // On a tie the port that did not own the last transaction wins.
   assign win       = (r0_req & r1_req) ? ~grant : r1_req;
   assign last_beat = cur_byte ? 2'd0 : 2'd3;

   // The final load byte arrives during RESP, so it is forwarded to the port
   // while ack is high and registered at the end of RESP.
   assign resp_result = cur_byte ? {24'h0, mem_rdata} : {mem_rdata, result[23:0]};
   assign r0_rdata = (state == RESP && !cur_write && !grant) ? resp_result : rdata0_q;
   assign r1_rdata = (state == RESP && !cur_write &&  grant) ? resp_result : rdata1_q;

   // Control state
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= 1'b1;
         beat     <= 2'd0;
         result   <= 32'h0;
         rdata0_q <= 32'h0;
         rdata1_q <= 32'h0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (any_req) begin
               grant  <= win;
               beat   <= 2'd0;
               result <= 32'h0;
            end
            XFER: begin
               beat <= beat + 2'd1;
               if (!cur_write) begin
                  case (beat)
                     2'd1:    result[7:0]   <= mem_rdata;
                     2'd2:    result[15:8]  <= mem_rdata;
                     2'd3:    result[23:16] <= mem_rdata;
                     default: ;
                  endcase
               end
            end
            RESP: if (!cur_write) begin
               if (grant) rdata1_q <= resp_result;
               else       rdata0_q <= resp_result;
            end
            default: ;
         endcase
      end
   end

   // Transaction latch: requester inputs are ignored after this point
   always_ff @(posedge clk) begin
      if (state == IDLE && any_req) begin
         cur_write <= win ? r1_write : r0_write;
         cur_byte  <= win ? r1_byte  : r0_byte;
         cur_addr  <= win ? r1_addr  : r0_addr;
         cur_wdata <= win ? r1_wdata : r0_wdata;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_addr  = '0;
      mem_wdata = 8'h0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      busy      = 1'b0;
      r0_ack    = 1'b0;
      r1_ack    = 1'b0;
      case (state)
         IDLE: if (any_req) state_nxt = XFER;
         XFER: begin
            busy     = 1'b1;
            mem_addr = cur_addr + ADDR_W'(beat);
            if (cur_write) begin
               mem_we    = 1'b1;
               mem_wdata = byte_lane(cur_wdata, beat);
            end else begin
               mem_re = 1'b1;
            end
            if (beat == last_beat) state_nxt = RESP;
         end
         RESP: begin
            busy      = 1'b1;
            r0_ack    = ~grant;
            r1_ack    = grant;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte memory model and a write log.
module tb_data_mem_arbiter;

   localparam int ADDR_W = 18;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              r0_req = 0, r0_write = 0, r0_byte = 0;
   logic [ADDR_W-1:0] r0_addr = '0;
   logic [31:0]       r0_wdata = '0;
   logic              r1_req = 0, r1_write = 0, r1_byte = 0;
   logic [ADDR_W-1:0] r1_addr = '0;
   logic [31:0]       r1_wdata = '0;
   logic              r0_ack, r1_ack, mem_we, mem_re, busy, grant;
   logic [31:0]       r0_rdata, r1_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata = 8'h0;

   logic              bd_we = 1'b0;
   logic [ADDR_W-1:0] bd_addr = '0;
   logic [7:0]        bd_data = 8'h0;
   logic [7:0]        mem [0:(1<<ADDR_W)-1];

   typedef struct {int cyc; logic [ADDR_W-1:0] addr; logic [7:0] data;} wr_t;
   wr_t wlog[$];
   int  cyc = 0;
   int  overlap_cnt = 0;
   int  passed = 0;
   int  total = 0;

   data_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_write(r0_write), .r0_byte(r0_byte), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_write(r1_write), .r1_byte(r1_byte), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wlog.push_back('{cyc, mem_addr, mem_wdata});
      end
      if (mem_re) mem_rdata <= mem[mem_addr];
      cyc <= cyc + 1;
   end

   always @(negedge clk) if (mem_we && mem_re) overlap_cnt <= overlap_cnt + 1;

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic wait_ack(input int port, output int ack_cyc, output int other);
      bit done = 0;
      ack_cyc = -1; other = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if ((port == 0) ? r1_ack : r0_ack) other++;
         if ((port == 0) ? r0_ack : r1_ack) begin ack_cyc = cyc; done = 1; end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if ({r0_ack, r1_ack, mem_we, mem_re, busy} !== 5'b0) $display("FAIL reset_ctl: got %b required 00000", {r0_ack, r1_ack, mem_we, mem_re, busy}); else passed++;
      total++; if (grant !== 1'b1) $display("FAIL reset_grant: got %b required 1", grant); else passed++;
      total++; if ({r0_rdata, r1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h required 0", {r0_rdata, r1_rdata}); else passed++;
      total++; if (mem_addr !== '0 || mem_wdata !== 8'h0) $display("FAIL reset_mem: got %h/%h required 0/0", mem_addr, mem_wdata); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_word_store;
      int t0, ac, oth, base;
      logic [7:0] exp_d [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      @(negedge clk);
      base = wlog.size(); t0 = cyc;
      r0_req = 1; r0_write = 1; r0_byte = 0; r0_addr = 18'h10; r0_wdata = 32'hDEADBEEF;
      wait_ack(0, ac, oth);
      total++; if (grant !== 1'b0) $display("FAIL ws_grant: got %b required 0", grant); else passed++;
      r0_req = 0;
      total++; if (ac !== t0 + 5) $display("FAIL ws_ack_cycle: got %0d required %0d", ac, t0 + 5); else passed++;
      total++; if (oth !== 0) $display("FAIL ws_r1_ack: got %0d required 0", oth); else passed++;
      total++; if (wlog.size() - base !== 4) $display("FAIL ws_nwrites: got %0d required 4", wlog.size() - base); else passed++;
      for (int k = 0; k < 4 && base + k < wlog.size(); k++) begin
         total++;
         if (wlog[base+k].cyc !== t0 + 1 + k || wlog[base+k].addr !== 18'h10 + k || wlog[base+k].data !== exp_d[k])
            $display("FAIL ws_beat%0d: got cyc %0d addr %h data %h required cyc %0d addr %h data %h", k,
                     wlog[base+k].cyc, wlog[base+k].addr, wlog[base+k].data, t0 + 1 + k, 18'h10 + k, exp_d[k]);
         else passed++;
      end
   endtask

   task automatic test_word_load;
      int t0, ac, oth;
      poke(18'h20, 8'h78); poke(18'h21, 8'h56); poke(18'h22, 8'h34); poke(18'h23, 8'h12);
      t0 = cyc;
      r1_req = 1; r1_write = 0; r1_byte = 0; r1_addr = 18'h20; r1_wdata = 32'hFFFFFFFF;
      wait_ack(1, ac, oth);
      r1_req = 0;
      total++; if (ac !== t0 + 5) $display("FAIL wl_ack_cycle: got %0d required %0d", ac, t0 + 5); else passed++;
      total++; if (r1_rdata !== 32'h12345678) $display("FAIL wl_rdata_at_ack: got %h required 12345678", r1_rdata); else passed++;
      total++; if (oth !== 0) $display("FAIL wl_r0_ack: got %0d required 0", oth); else passed++;
      @(negedge clk);
      total++; if (r1_rdata !== 32'h12345678) $display("FAIL wl_rdata_held: got %h required 12345678", r1_rdata); else passed++;
      total++; if (r0_rdata !== 32'h0) $display("FAIL wl_r0_rdata: got %h required 0", r0_rdata); else passed++;
   endtask

   task automatic test_byte_ops;
      int t0, ac, oth, base;
      poke(18'h23, 8'h9C);
      t0 = cyc;
      r0_req = 1; r0_write = 0; r0_byte = 1; r0_addr = 18'h23;
      wait_ack(0, ac, oth);
      r0_req = 0;
      total++; if (ac !== t0 + 2) $display("FAIL bl_ack_cycle: got %0d required %0d", ac, t0 + 2); else passed++;
      total++; if (r0_rdata !== 32'h0000009C) $display("FAIL bl_rdata: got %h required 0000009C", r0_rdata); else passed++;
      total++; if (r1_rdata !== 32'h12345678) $display("FAIL bl_r1_rdata: got %h required 12345678", r1_rdata); else passed++;
      @(negedge clk);
      base = wlog.size(); t0 = cyc;
      r0_req = 1; r0_write = 1; r0_byte = 1; r0_addr = 18'h05; r0_wdata = 32'hAABBCC55;
      wait_ack(0, ac, oth);
      r0_req = 0;
      total++; if (ac !== t0 + 2) $display("FAIL bs_ack_cycle: got %0d required %0d", ac, t0 + 2); else passed++;
      total++; if (wlog.size() - base !== 1) $display("FAIL bs_nwrites: got %0d required 1", wlog.size() - base); else passed++;
      if (wlog.size() > base) begin
         total++; if (wlog[base].addr !== 18'h05 || wlog[base].data !== 8'h55) $display("FAIL bs_write: got %h/%h required 00005/55", wlog[base].addr, wlog[base].data); else passed++;
      end
      total++; if (r0_rdata !== 32'h0000009C) $display("FAIL bs_r0_rdata: got %h required 0000009C", r0_rdata); else passed++;
   endtask

   task automatic test_back_to_back;
      int t0, n, both, idle_bad;
      int ack_port [4];
      int ack_c [4];
      bit prev_ack;
      logic [31:0] w0, w1;
      w0 = 32'h11223344; w1 = 32'h55667788;
      reset = 1;
      @(negedge clk);
      reset = 0;
      t0 = cyc;
      r0_req = 1; r0_write = 1; r0_byte = 0; r0_addr = 18'h40; r0_wdata = w0;
      r1_req = 1; r1_write = 1; r1_byte = 0; r1_addr = 18'h80; r1_wdata = w1;
      n = 0; both = 0; idle_bad = 0; prev_ack = 0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(negedge clk);
         if (prev_ack && busy) idle_bad++;
         prev_ack = r0_ack | r1_ack;
         if (r0_ack && r1_ack) both++;
         if (r0_ack) begin ack_port[n] = 0; ack_c[n] = cyc; n++; end
         else if (r1_ack) begin ack_port[n] = 1; ack_c[n] = cyc; n++; end
      end
      r0_req = 0; r1_req = 0;
      total++; if (n !== 4) $display("FAIL b2b_ack_count: got %0d required 4", n); else passed++;
      for (int k = 0; k < n; k++) begin
         total++;
         if (ack_port[k] !== k % 2 || ack_c[k] !== t0 + 5 + 6 * k)
            $display("FAIL b2b_ack%0d: got port %0d cyc %0d required port %0d cyc %0d", k, ack_port[k], ack_c[k], k % 2, t0 + 5 + 6 * k);
         else passed++;
      end
      total++; if (both !== 0 || idle_bad !== 0) $display("FAIL b2b_spacing: got both %0d busy_after_ack %0d required 0 0", both, idle_bad); else passed++;
      @(negedge clk);
      total++;
      if ({mem[18'h43], mem[18'h42], mem[18'h41], mem[18'h40]} !== w0 || {mem[18'h83], mem[18'h82], mem[18'h81], mem[18'h80]} !== w1)
         $display("FAIL b2b_data: got %h %h required %h %h", {mem[18'h43], mem[18'h42], mem[18'h41], mem[18'h40]},
                  {mem[18'h83], mem[18'h82], mem[18'h81], mem[18'h80]}, w0, w1);
      else passed++;
      total++; if (overlap_cnt !== 0) $display("FAIL we_re_overlap: got %0d required 0", overlap_cnt); else passed++;
   endtask

   task automatic test_wrap;
      int ac, oth, base;
      logic [ADDR_W-1:0] exp_a [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
      logic [7:0] exp_d [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      @(negedge clk);
      base = wlog.size();
      r0_req = 1; r0_write = 1; r0_byte = 0; r0_addr = 18'h3FFFE; r0_wdata = 32'hA1B2C3D4;
      wait_ack(0, ac, oth);
      r0_req = 0;
      total++; if (wlog.size() - base !== 4 || ac < 0) $display("FAIL wrap_nwrites: got %0d ack %0d required 4", wlog.size() - base, ac); else passed++;
      for (int k = 0; k < 4 && base + k < wlog.size(); k++) begin
         total++;
         if (wlog[base+k].addr !== exp_a[k] || wlog[base+k].data !== exp_d[k])
            $display("FAIL wrap_beat%0d: got %h/%h required %h/%h", k, wlog[base+k].addr, wlog[base+k].data, exp_a[k], exp_d[k]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid;
      int ac, oth, base, t0, stray;
      @(negedge clk);
      r0_req = 1; r0_write = 0; r0_byte = 1; r0_addr = 18'h23;
      wait_ack(0, ac, oth);
      r0_req = 0;
      @(negedge clk);
      base = wlog.size();
      r0_req = 1; r0_write = 1; r0_byte = 0; r0_addr = 18'h100; r0_wdata = 32'hCAFEF00D;
      repeat (2) @(negedge clk);
      reset = 1; r0_req = 0;
      @(negedge clk);
      total++; if ({busy, mem_we, mem_re, r0_ack} !== 4'b0) $display("FAIL rm_ctl: got %b required 0000", {busy, mem_we, mem_re, r0_ack}); else passed++;
      total++; if (grant !== 1'b1) $display("FAIL rm_grant: got %b required 1", grant); else passed++;
      total++; if (r0_rdata !== 32'h0) $display("FAIL rm_rdata_clear: got %h required 0", r0_rdata); else passed++;
      reset = 0;
      stray = 0;
      repeat (4) begin @(negedge clk); if (r0_ack || r1_ack || busy) stray++; end
      total++; if (stray !== 0) $display("FAIL rm_no_ack: got %0d active cycles required 0", stray); else passed++;
      total++;
      if (wlog.size() - base !== 2) $display("FAIL rm_nwrites: got %0d required 2", wlog.size() - base);
      else if (wlog[base].addr !== 18'h100 || wlog[base].data !== 8'h0D || wlog[base+1].addr !== 18'h101 || wlog[base+1].data !== 8'hF0)
         $display("FAIL rm_writes: got %h/%h %h/%h required 00100/0d 00101/f0", wlog[base].addr, wlog[base].data, wlog[base+1].addr, wlog[base+1].data);
      else passed++;
      t0 = cyc;
      r1_req = 1; r1_write = 0; r1_byte = 1; r1_addr = 18'h101;
      wait_ack(1, ac, oth);
      r1_req = 0;
      total++; if (ac !== t0 + 2) $display("FAIL rm_fresh_ack: got %0d required %0d", ac, t0 + 2); else passed++;
      total++; if (r1_rdata !== 32'h000000F0) $display("FAIL rm_fresh_rdata: got %h required 000000F0", r1_rdata); else passed++;
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_word_load();
      test_byte_ops();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Sequencing arbiter that shares the byte-wide data memory between two word-oriented requesters: port 0, the CPU load/store unit, and port 1, the DMA/debug loader. Each granted request is executed as a series of single-byte memory cycles: one beat for byte operations (lb/sb), four little-endian beats for word operations (lw/sw). The requester gets a one-cycle acknowledge when the transaction finishes. The block sits between the pipeline's MEM stage and the data memory.

## Interface
Parameters:
- ADDR_W, 18, byte-address width; address arithmetic wraps modulo 2^ADDR_W

Ports (N = 0, 1):
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- rN_req  in  1  request; held high until rN_ack
- rN_write  in  1  1 = store, 0 = load
- rN_byte  in  1  1 = single-byte access, 0 = 32-bit word access
- rN_addr  in  ADDR_W  byte address
- rN_wdata  in  32  store data; a byte store uses [7:0]
- rN_ack  out  1  one-cycle completion pulse
- rN_rdata  out  32  load result; held until that port's next load completes
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  8  byte write data
- mem_we  out  1  byte write strobe
- mem_re  out  1  byte read strobe; mem_rdata is valid the cycle after mem_re
- mem_rdata  in  8  byte read data
- busy  out  1  high from the XFER state through the RESP state
- grant  out  1  owner of the current or last transaction (0/1)

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If any rN_req is high, arbitrate, latch the winner's write/byte/addr/wdata, clear the beat counter, and go to XFER.
  - If no request is high, stay in IDLE.
- Arbitration is round-robin:
  - When both requesters are asking, the one that is not `grant` wins.
  - A lone requester always wins.
  - After reset, `grant` = 1, so port 0 wins the first tie.
- XFER: beat count NB = 1 for a byte access, 4 for a word access.
  - On beat k (k = 0..NB-1), drive mem_addr = (addr + k) mod 2^ADDR_W.
  - For a store, drive mem_we = 1 and mem_wdata = wdata[8k+7:8k].
  - For a load, drive mem_re = 1.
  - After beat NB-1, go to RESP.
- Load capture: mem_rdata from beat k is captured the following cycle into result[8k+7:8k]. Beat NB-1 is captured in RESP.
  - A byte load zero-extends: result = {24'h0, byte}.
- RESP:
  - Pulse ack for the granted port.
  - For a load, update that port's rdata with the full result in the same edge that raises ack.
  - mem_we and mem_re are low.
  - Go to IDLE.
- Unaligned word addresses are legal; no alignment check is performed.
- Requester inputs are ignored after the latch. A requester that drops req or changes its inputs mid-transaction does not alter the transaction, and ack is still issued.
- The losing requester waits with no side effects. The other port's rdata is never modified.

## Timing
- Reset values: all outputs 0 except grant = 1; FSM is in IDLE; beat counter and result are 0.
- Let T be the edge on which IDLE samples a request.
  - XFER occupies cycles T+1 .. T+NB.
  - RESP, and therefore ack, is at cycle T+NB+1.
  - Word latency is 5 cycles; byte latency is 2 cycles.
- After RESP there is at least one IDLE cycle, so back-to-back transactions are spaced NB+2 cycles apart.
- A requester that keeps req high after its ack is treated as a new request at the next IDLE.
- mem_we and mem_re are never high at the same time, and never high outside XFER.
- Reset mid-transaction:
  - Abort immediately; mem_we, mem_re and busy are low from the next cycle.
  - No ack is issued; rdata registers clear to 0; grant returns to 1.
  - Bytes already written stay written.
- Address wrap: a word access at 2^ADDR_W-2 touches 3FFFE, 3FFFF, 00000, 00001 (ADDR_W = 18).

## Test plan
- r0 word store, addr 0x10, wdata 0xDEADBEEF -> mem_we with (0x10, EF), (0x11, BE), (0x12, AD), (0x13, DE) on cycles T+1..T+4; r0_ack at T+5; r1_ack stays 0.
- Memory bytes 0x20..0x23 = 78, 56, 34, 12; r1 word load at 0x20 -> r1_rdata = 0x12345678 with r1_ack at T+5; r0_rdata unchanged.
- r0 byte load at 0x23 holding 0x9C -> r0_rdata = 0x0000009C, ack at T+2. r0 byte store of 0xAABBCC55 at 0x05 -> a single write (0x05, 55).
- Both requesters hold req continuously from reset -> grants alternate 0, 1, 0, 1; each ack is followed by at least one idle cycle; data lands at each port's own address.
- Word store at 0x3FFFE -> writes go to 3FFFE, 3FFFF, 00000, 00001.
- Reset asserted at T+2 of a word store -> only 2 bytes are written, no ack, busy = 0 and grant = 1 the cycle after reset; a fresh r1 request afterwards completes normally.
